// File: rtl/seg7_scan_bcd.sv
// seg7_scan_bcd: converts an 8-bit unsigned value to 3-digit BCD with a
// sequential double-dabble engine, then scans the digits onto a
// common-anode 3-digit 7-segment display with leading-zero blanking.
module seg7_scan_bcd #(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic        Clk,
    input  logic        RST_N,
    input  logic [7:0]  Din,
    output logic        Busy,
    output logic [11:0] Bcd,
    output logic [7:0]  Seg,
    output logic [2:0]  Sel
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state;
    logic [7:0]  last;
    logic [19:0] sr;
    logic [2:0]  iter;
    logic [19:0] sr_adj;
    logic [19:0] sr_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]  idx;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    function automatic logic [11:0] adj3(input logic [11:0] b);
        logic [11:0] r;
        logic [3:0]  nib;
        r = b;
        for (int i = 0; i < 3; i++) begin
            nib = b[4*i +: 4];
            if (nib >= 4'd5)
                r[4*i +: 4] = nib + 4'd3;
        end
        return r;
    endfunction

    // Active-low segment pattern for one decimal digit; dp stays off.
    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    assign sr_adj = {adj3(sr[19:8]), sr[7:0]};
    assign sr_nxt = sr_adj << 1;

    // Converter: start on a new Din in IDLE, then eight adjust-and-shift steps.
    always_ff @(posedge Clk or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            last  <= 8'h00;
            sr    <= 20'h0;
            iter  <= 3'd0;
            Busy  <= 1'b0;
            Bcd   <= 12'h000;
        end else begin
            case (state)
                IDLE: begin
                    if (Din != last) begin
                        sr    <= {12'b0, Din};
                        last  <= Din;
                        iter  <= 3'd0;
                        Busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr <= sr_nxt;
                    if (iter == 3'd7) begin
                        Bcd   <= sr_nxt[19:8];
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        iter <= iter + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Scan prescaler; each wrap moves on to the next digit (units, tens, hundreds).
    always_ff @(posedge Clk or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CNT_W'(SCAN_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Register digit select and segments from the current digit and Bcd.
    always_ff @(posedge Clk or negedge RST_N) begin
        if (!RST_N) begin
            Sel <= 3'b111;
            Seg <= 8'hFF;
        end else begin
            case (idx)
                2'd0: begin
                    Sel <= 3'b110;
                    Seg <= seg7(Bcd[3:0]);
                end
                2'd1: begin
                    Sel <= 3'b101;
                    Seg <= (Bcd[11:4] == 8'h00) ? 8'hFF : seg7(Bcd[7:4]);
                end
                2'd2: begin
                    Sel <= 3'b011;
                    Seg <= (Bcd[11:8] == 4'h0) ? 8'hFF : seg7(Bcd[11:8]);
                end
                default: begin
                    Sel <= 3'b111;
                    Seg <= 8'hFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_bcd.sv
// Bench for seg7_scan_bcd: directed scenarios plus random Din traffic and a
// full 0..255 sweep, checked every cycle against a decimal-arithmetic model.
module tb_seg7_scan_bcd;

    localparam int SD = 4;

    logic        Clk = 1'b0;
    logic        RST_N = 1'b0;
    logic [7:0]  Din = 8'h00;
    logic        Busy;
    logic [11:0] Bcd;
    logic [7:0]  Seg;
    logic [2:0]  Sel;

    int checks = 0;
    int errors = 0;

    // model state
    int k;          // edges since reset release
    int m_num;      // value currently shown in Bcd
    int m_last;
    int m_val;
    int m_done;
    bit m_busy;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    seg7_scan_bcd #(.SCAN_DIV(SD), .CNT_W(4)) dut (
        .Clk(Clk), .RST_N(RST_N), .Din(Din),
        .Busy(Busy), .Bcd(Bcd), .Seg(Seg), .Sel(Sel)
    );

    always #5 Clk = ~Clk;

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic logic [7:0] exp_seg(input int d, input int n);
        case (d)
            0:       return seg_tab[n % 10];
            1:       return (n < 10)  ? 8'hFF : seg_tab[(n / 10) % 10];
            default: return (n < 100) ? 8'hFF : seg_tab[n / 100];
        endcase
    endfunction

    function automatic logic [2:0] exp_sel(input int d);
        case (d)
            0:       return 3'b110;
            1:       return 3'b101;
            default: return 3'b011;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, k);
        end
    endtask

    task automatic model_reset();
        k = 0; m_num = 0; m_last = 0; m_busy = 0; m_done = 0; m_val = 0;
    endtask

    // One rising edge; advance the model and compare all outputs.
    task automatic tick();
        int din_s, num_pre, d;
        din_s = int'(Din);
        num_pre = m_num;
        @(posedge Clk);
        #1;
        k++;
        d = ((k - 1) / SD) % 3;
        if (m_busy) begin
            if (k == m_done) begin
                m_num  = m_val;
                m_busy = 0;
            end
        end else if (din_s != m_last) begin
            m_last = din_s;
            m_val  = din_s;
            m_busy = 1;
            m_done = k + 8;
        end
        chk("busy", 16'(Busy), 16'(m_busy));
        chk("bcd",  16'(Bcd),  16'(to_bcd(m_num)));
        chk("sel",  16'(Sel),  16'(exp_sel(d)));
        chk("seg",  16'(Seg),  16'(exp_seg(d, num_pre)));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reset_check();
        chk("rst_busy", 16'(Busy), 16'h0);
        chk("rst_bcd",  16'(Bcd),  16'h000);
        chk("rst_seg",  16'(Seg),  16'hFF);
        chk("rst_sel",  16'(Sel),  16'b111);
    endtask

    task automatic release_reset();
        @(negedge Clk);
        RST_N = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        #12;
        reset_check();
        release_reset();

        // Din=0 after reset: no conversion, display shows "0"
        ticks(14);

        // 255: busy for 8 cycles, then 2/5/5 on the scan
        Din = 8'd255;
        ticks(9);
        chk("bcd_255", 16'(Bcd), 16'h255);
        ticks(14);

        // 7: tens and hundreds blanked
        Din = 8'd7;
        ticks(9);
        chk("bcd_7", 16'(Bcd), 16'h007);
        ticks(14);

        // 105: inner zero stays visible
        Din = 8'd105;
        ticks(9);
        chk("bcd_105", 16'(Bcd), 16'h105);
        ticks(14);

        // change during conversion is picked up right after completion
        Din = 8'd10;
        ticks(3);            // E0..E2
        Din = 8'd200;        // sampled by E3, ignored while busy
        ticks(6);            // E3..E8
        chk("bcd_10", 16'(Bcd), 16'h010);
        ticks(9);            // E9..E17
        chk("bcd_200", 16'(Bcd), 16'h200);
        ticks(6);

        // reset in the middle of a conversion
        Din = 8'd99;
        ticks(5);            // E0..E4
        RST_N = 1'b0;
        #1;
        reset_check();
        release_reset();
        ticks(9);
        chk("bcd_99", 16'(Bcd), 16'h099);
        ticks(6);

        // random traffic, including changes while busy
        for (int r = 0; r < 60; r++) begin
            Din = 8'($urandom_range(0, 255));
            ticks($urandom_range(1, 12));
        end
        ticks(10);

        // full sweep of every input value
        for (int v = 0; v < 256; v++) begin
            Din = 8'(v);
            ticks(9);
            chk("sweep", 16'(Bcd), 16'(to_bcd(v)));
        end
        ticks(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_bcd.md
Name: seg7_scan_bcd

Overview:
- Downstream display stage for the 8-bit free-running divider count on the exam board.
- Takes the unsigned 8-bit value and converts it to 3-digit BCD (000–255) with a sequential shift-add-3 (double-dabble) engine.
- Drives a time-multiplexed, common-anode 3-digit 7-segment display with leading-zero blanking.

Parameters:
- SCAN_DIV, 50000: Clk cycles each digit stays selected. Minimum 2; the bench uses 4.
- CNT_W, 16: width of the scan prescaler. Must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- Clk  in  1  system clock; all state on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- Din  in  8  unsigned value to display (upstream divider count).
- Busy  out  1  high while a BCD conversion is in progress.
- Bcd  out  12  registered result: [11:8] hundreds, [7:4] tens, [3:0] units.
- Seg  out  8  active-low segments: [0]=a … [6]=g, [7]=dp (dp always 1).
- Sel  out  3  active-low digit select: [0]=units, [1]=tens, [2]=hundreds.

Behaviour:
- Reset (async, RST_N=0):
  - Bcd=12'h000, Busy=0, Seg=8'hFF, Sel=3'b111.
  - FSM=IDLE, Last=8'h00, digit index=0, prescaler=0.
- Converter FSM states: IDLE, SHIFT.
- IDLE:
  - Each edge, compare Din with Last.
  - If they differ: load the 20-bit shift register with {12'b0, Din}, set Last<=Din, iter<=0, Busy<=1, go to SHIFT.
  - Else stay in IDLE.
- SHIFT, one iteration per edge:
  - First, add 3 to each BCD nibble that is >=5.
  - Then shift the whole register left by 1.
  - On the edge where iter==7: write Bcd from the post-shift bits [19:8], set Busy<=0, return to IDLE.
  - Otherwise iter<=iter+1.
- Latency:
  - Din is sampled at edge E0.
  - Bcd updates and Busy falls at E8.
  - Busy is high for exactly 8 cycles.
- Din changes while Busy=1 are ignored. On the first IDLE edge after completion, Last≠Din triggers a fresh conversion; no back-to-back IDLE gap beyond that one edge.
- Din==Last in IDLE means no conversion. After reset, Din=0 never triggers one; the display shows "0".
- Scan prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - On the wrap edge, digit index advances 0→1→2→0. Index 3 is never reached.
- Sel and Seg are registered every edge from the current index and current Bcd, so they lag the index by one cycle.
  - Sel is one-hot low on the selected digit.
- Segment codes for digits 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex).
- Nibble values above 9 cannot occur. If one does, drive 8'hFF.
- Blanking:
  - Hundreds is blanked (Seg=8'hFF) when Bcd[11:8]==0.
  - Tens is blanked when Bcd[11:8]==0 and Bcd[7:4]==0.
  - Units is never blanked.
  - Sel still asserts for a blanked digit.
- A Bcd update mid-digit takes effect on Seg the next edge; the scan timing is not disturbed.
- Reset mid-conversion aborts immediately to reset values. The next conversion starts only on a Din≠0 after release.

Test Plan:
- Reset, then Din=8'd255 -> Busy high for 8 cycles; Bcd=12'h255 at E8; with SCAN_DIV=4, Sel cycles 110,101,011 every 4 cycles with Seg 92,92,A4.
- Din=8'd7 -> Bcd=12'h007; units Seg=F8; tens and hundreds Seg=FF while their Sel bits are low.
- Din=8'd105 -> Bcd=12'h105; tens shows C0 (not blanked); hundreds F9; units 92.
- Din=8'd10 at E0, then Din=8'd200 at E3 -> Bcd=12'h010 at E8; next conversion starts at E9; Bcd=12'h200 at E17.
- Din=8'd99, assert RST_N=0 at E4 -> Busy=0, Bcd=0, Seg=FF, Sel=111 asynchronously; after release Din=99 converts again to 12'h099.
- Sweep Din 0..255 via a model counter -> Bcd matches the decimal value for all 256 inputs.
